// File: rtl/hawk_pkg.sv
// hawk_pkg: shared definitions for the HAWK pedestrian beacon controller.
//   - hawk_state_e : 4-bit state codes (DARK..FLASH_R); codes 5-15 are illegal.
//   - DEF_*_CYCLES : default durations of the timed states, in clocks.
//   - lamps_t      : bundle of lamp / pedestrian-head drives.
//   - lamp_decode  : Moore output decode from a state code and the flash phase.
package hawk_pkg;

    typedef enum logic [3:0] {
        DARK     = 4'd0,
        FLASH_Y  = 4'd1,
        STEADY_Y = 4'd2,
        RED_WALK = 4'd3,
        FLASH_R  = 4'd4
    } hawk_state_e;

    localparam int unsigned DEF_FY_CYCLES = 4;
    localparam int unsigned DEF_SY_CYCLES = 3;
    localparam int unsigned DEF_RW_CYCLES = 6;
    localparam int unsigned DEF_FR_CYCLES = 6;
    localparam int unsigned DEF_CNT_W     = 8;

    typedef struct packed {
        logic yl;
        logic rl;
        logic w;
        logic dnw;
    } lamps_t;

    // flash is high in the first clock of a flashing state, then alternates.
    function automatic lamps_t lamp_decode(input hawk_state_e state, input logic flash);
        lamps_t l;
        l = '{yl: 1'b0, rl: 1'b0, w: 1'b0, dnw: 1'b1};
        case (state)
            FLASH_Y:  l.yl = flash;
            STEADY_Y: l.yl = 1'b1;
            RED_WALK: l = '{yl: 1'b0, rl: 1'b1, w: 1'b1, dnw: 1'b0};
            FLASH_R:  l = '{yl: 1'b0, rl: flash, w: 1'b0, dnw: flash};
            default:  l = '{yl: 1'b0, rl: 1'b0, w: 1'b0, dnw: 1'b1};
        endcase
        return l;
    endfunction

endpackage

// File: rtl/hawk_if.sv
// hawk_if: push-button inputs, lamp outputs and debug signals of the HAWK controller.
//   YP, NS                  : pedestrian push-buttons (level, active-high)
//   YL, RL                  : yellow / red vehicle beacon lamps
//   W, DNW                  : WALK / DON'T WALK pedestrian heads
//   clr_count, inc_count    : timer controls (debug)
//   present_state, next_state : registered / combinational state codes (debug)
// Modports: master = environment (drives buttons), slave = controller.
interface hawk_if;
    logic       YP;
    logic       NS;
    logic       YL;
    logic       RL;
    logic       W;
    logic       DNW;
    logic       clr_count;
    logic       inc_count;
    logic [3:0] present_state;
    logic [3:0] next_state;

    modport master (
        output YP, NS,
        input  YL, RL, W, DNW, clr_count, inc_count, present_state, next_state
    );

    modport slave (
        input  YP, NS,
        output YL, RL, W, DNW, clr_count, inc_count, present_state, next_state
    );
endinterface

// File: rtl/hawk_timer.sv
// hawk_timer: CNT_W-bit cycle timer with synchronous active-high reset.
//   clk, reset : clock and synchronous reset
//   clr        : next count = 0 (has priority over inc)
//   inc        : next count = count + 1
//   count      : registered count
//   count_next : value count takes at the next edge (absent reset)
module hawk_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_next
);

    always_comb begin
        count_next = count;
        if (clr) begin
            count_next = '0;
        end else if (inc) begin
            count_next = count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/hawk_controller.sv
// hawk_controller: HAWK pedestrian beacon sequencer (Moore FSM + cycle timer).
// A request (YP | NS) seen in DARK runs one sequence:
//   DARK -> FLASH_Y -> STEADY_Y -> RED_WALK -> FLASH_R -> DARK
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : hawk_if.slave (buttons in; lamps, timer controls, state codes out)
// Optional feature: define HAWK_REQ_LATCH_EN to remember a press made during a
// sequence and serve it right after the single DARK clock.
module hawk_controller
    import hawk_pkg::*;
#(
    parameter int unsigned FY_CYCLES = DEF_FY_CYCLES,
    parameter int unsigned SY_CYCLES = DEF_SY_CYCLES,
    parameter int unsigned RW_CYCLES = DEF_RW_CYCLES,
    parameter int unsigned FR_CYCLES = DEF_FR_CYCLES,
    parameter int unsigned CNT_W     = DEF_CNT_W
) (
    input  logic  clk,
    input  logic  reset,
    hawk_if.slave bus
);

    hawk_state_e      state_q;
    hawk_state_e      state_d;
    lamps_t           lamps_q;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [CNT_W-1:0] last_count;
    logic             req;
    logic             start;
    logic             done;
    logic             timed;
    logic             clr;
    logic             inc;

    assign req = bus.YP | bus.NS;

`ifdef HAWK_REQ_LATCH_EN
    logic pending_q;
    assign start = req | pending_q;
`else
    assign start = req;
`endif

    // Terminal count of the current timed state.
    always_comb begin
        last_count = '0;
        case (state_q)
            FLASH_Y:  last_count = CNT_W'(FY_CYCLES - 1);
            STEADY_Y: last_count = CNT_W'(SY_CYCLES - 1);
            RED_WALK: last_count = CNT_W'(RW_CYCLES - 1);
            FLASH_R:  last_count = CNT_W'(FR_CYCLES - 1);
            default:  last_count = '0;
        endcase
    end

    assign done  = (count == last_count);
    assign timed = (state_q == FLASH_Y) || (state_q == STEADY_Y) ||
                   (state_q == RED_WALK) || (state_q == FLASH_R);

    always_comb begin
        state_d = state_q;
        case (state_q)
            DARK:     if (start) state_d = FLASH_Y;
            FLASH_Y:  if (done)  state_d = STEADY_Y;
            STEADY_Y: if (done)  state_d = RED_WALK;
            RED_WALK: if (done)  state_d = FLASH_R;
            FLASH_R:  if (done)  state_d = DARK;
            default:  state_d = DARK;
        endcase
    end

    // The timer is held at 0 throughout DARK and restarts on every state change.
    assign clr = (state_d != state_q) || (state_q == DARK);
    assign inc = timed && (state_d == state_q);

    hawk_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .clr        (clr),
        .inc        (inc),
        .count      (count),
        .count_next (count_next)
    );

    // Lamps are registered from the next state and next count, so they equal the
    // Moore decode of (present_state, count) in every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= DARK;
            lamps_q <= lamp_decode(DARK, 1'b1);
`ifdef HAWK_REQ_LATCH_EN
            pending_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            lamps_q <= lamp_decode(state_d, ~count_next[0]);
`ifdef HAWK_REQ_LATCH_EN
            if (state_q != DARK && req) begin
                pending_q <= 1'b1;
            end else if (state_q == DARK && state_d == FLASH_Y) begin
                pending_q <= 1'b0;
            end
`endif
        end
    end

    assign bus.YL            = lamps_q.yl;
    assign bus.RL            = lamps_q.rl;
    assign bus.W             = lamps_q.w;
    assign bus.DNW           = lamps_q.dnw;
    assign bus.clr_count     = clr;
    assign bus.inc_count     = inc;
    assign bus.present_state = state_q;
    assign bus.next_state    = state_d;

endmodule

// File: tb/tb_hawk_controller.sv
// tb_hawk_controller: self-checking bench for hawk_controller with default parameters.
// The reference model tracks the position within the 19-clock beacon sequence
// (0 = dark) and derives state, timer value and lamps from that position.
module tb_hawk_controller;

    localparam int FY    = 4;
    localparam int SY    = 3;
    localparam int RW    = 6;
    localparam int FR    = 6;
    localparam int TOTAL = FY + SY + RW + FR;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;

    // Model state
    int   pos;
    logic pend;
    logic model_valid;

    hawk_if bus ();

    hawk_controller #(
        .FY_CYCLES (FY),
        .SY_CYCLES (SY),
        .RW_CYCLES (RW),
        .FR_CYCLES (FR),
        .CNT_W     (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Map a sequence position onto (state code, clocks spent in that state).
    task automatic pos_decode(input int p, output logic [3:0] st, output int off);
        int k;
        st  = 4'd0;
        off = 0;
        if (p != 0) begin
            k = p - 1;
            if (k < FY) begin
                st = 4'd1; off = k;
            end else if (k < FY + SY) begin
                st = 4'd2; off = k - FY;
            end else if (k < FY + SY + RW) begin
                st = 4'd3; off = k - FY - SY;
            end else begin
                st = 4'd4; off = k - FY - SY - RW;
            end
        end
    endtask

    function automatic int next_pos(input int p, input logic go);
        if (p == 0) return go ? 1 : 0;
        return (p == TOTAL) ? 0 : p + 1;
    endfunction

    // Expected {YL, RL, W, DNW}.
    function automatic logic [3:0] exp_lamps(input logic [3:0] st, input int off);
        logic on;
        on = ((off % 2) == 0);
        case (st)
            4'd1:    return {on, 1'b0, 1'b0, 1'b1};
            4'd2:    return 4'b1001;
            4'd3:    return 4'b0110;
            4'd4:    return {1'b0, on, 1'b0, on};
            default: return 4'b0001;
        endcase
    endfunction

    task automatic cycle(input logic yp, input logic ns, input logic rst);
        logic [3:0] st;
        logic [3:0] nst;
        logic [3:0] lamps;
        int         off;
        int         noff;
        logic       go;
        bus.YP = yp;
        bus.NS = ns;
        reset  = rst;
        #1;
        if (model_valid) begin
            pos_decode(pos, st, off);
            lamps = exp_lamps(st, off);
            check("present_state", 8'(bus.present_state), 8'(st));
            check("count", dut.u_timer.count, 8'(off));
            check("lamps_yl_rl_w_dnw", 8'({bus.YL, bus.RL, bus.W, bus.DNW}), 8'(lamps));
            check("w_and_dnw", 8'(bus.W & bus.DNW), 8'd0);
            check("yl_and_rl", 8'(bus.YL & bus.RL), 8'd0);
            check("clr_and_inc", 8'(bus.clr_count & bus.inc_count), 8'd0);
            if (!rst) begin
                go = yp | ns | pend;
                pos_decode(next_pos(pos, go), nst, noff);
                check("next_state", 8'(bus.next_state), 8'(nst));
                check("clr_count", 8'(bus.clr_count), 8'((nst != st) || (st == 4'd0)));
                check("inc_count", 8'(bus.inc_count), 8'((st != 4'd0) && (nst == st)));
            end
        end
        @(posedge clk);
        if (rst) begin
            pos         = 0;
            pend        = 1'b0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            if (pos == 0) begin
                if (yp | ns | pend) begin
                    pos  = 1;
                    pend = 1'b0;
                end
            end else begin
`ifdef HAWK_REQ_LATCH_EN
                if (yp | ns) pend = 1'b1;
`endif
                pos = next_pos(pos, 1'b0);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_cmp       = 0;
        n_fail      = 0;
        pos         = 0;
        pend        = 1'b0;
        model_valid = 1'b0;
        bus.YP      = 1'b0;
        bus.NS      = 1'b0;
        reset       = 1'b1;

        // Reset, then idle in DARK.
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        check("reset_dnw", 8'(bus.DNW), 8'd1);
        check("reset_clr", 8'(bus.clr_count), 8'd1);
        idle(10);

        // YP pulse of 5 clocks: one full sequence.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0);
        idle(20);

        // NS held for 40 clocks: back-to-back sequences.
        for (int i = 0; i < 40; i++) cycle(1'b0, 1'b1, 1'b0);
        idle(45);

        // Reset during RED_WALK.
        cycle(1'b1, 1'b0, 1'b0);
        idle(8);
        check("in_red_walk", 8'(bus.present_state), 8'd3);
        cycle(1'b0, 1'b0, 1'b1);
        check("post_reset_state", 8'(bus.present_state), 8'd0);
        check("post_reset_w", 8'(bus.W), 8'd0);
        idle(3);

        // Press during STEADY_Y.
        cycle(1'b1, 1'b0, 1'b0);
        idle(5);
        check("in_steady_y", 8'(bus.present_state), 8'd2);
        cycle(1'b1, 1'b0, 1'b0);
        idle(45);

        // Randomized buttons with occasional reset.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) == 0),
                  1'($urandom_range(0, 59) == 0));
        end
        idle(25);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
